// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch, in-order FIFO of {instr, pc},
// redirect flush with stale-response dropping.
module instr_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_misaligned
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [XLEN-1:0] pc_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            misaligned_q, misaligned_d;

    logic [CW:0] credit_used;
    logic        head_valid;
    logic        req_fire;
    logic        rsp_keep;
    logic        rsp_drop;
    logic        pop;

    // Request credit covers both buffered and outstanding fetches, so the
    // FIFO can always absorb every response.
    assign credit_used    = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req_valid = rst_n & ~misaligned_q & ~redirect_valid
                          & (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;

    assign head_valid       = rst_n & ~misaligned_q & (count_q != '0);
    assign instr_valid      = head_valid;
    assign instruction      = head_valid ? data_q[rd_ptr_q] : '0;
    assign instr_pc         = head_valid ? pc_q[rd_ptr_q] : '0;
    assign fetch_misaligned = rst_n & misaligned_q;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign rsp_keep = imem_rsp_valid & (drop_q == '0);
    assign rsp_drop = imem_rsp_valid & (drop_q != '0);
    assign pop      = head_valid & instr_ready;

    // Next-state: redirect flushes everything, otherwise push/pop/fetch.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        rsp_pc_d     = rsp_pc_q;
        data_d       = data_q;
        pc_d         = pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        inflight_d   = inflight_q;
        drop_d       = drop_q;
        misaligned_d = misaligned_q;
        if (redirect_valid) begin
            // A response arriving now is discarded either way: it is an old
            // drop or one of the in-flight fetches being abandoned.
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            inflight_d   = '0;
            drop_d       = drop_q + inflight_q - CW'(imem_rsp_valid);
            fetch_pc_d   = redirect_addr;
            rsp_pc_d     = redirect_addr;
            misaligned_d = (redirect_addr[1:0] != 2'b00);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_keep) begin
                data_d[wr_ptr_q] = imem_rsp_data;
                pc_d[wr_ptr_q]   = rsp_pc_q;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                rsp_pc_d         = rsp_pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_keep);
            count_d    = count_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            rsp_pc_q     <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            drop_q       <= '0;
            misaligned_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            rsp_pc_q     <= rsp_pc_d;
            data_q       <= data_d;
            pc_q         <= pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            misaligned_q <= misaligned_d;
        end
    end
endmodule
